// File: rtl/posit_decoder.sv
// posit_decoder: multi-cycle field extractor for posit<32,3> words.
//
// A decode runs IDLE -> LOAD -> DECODE -> DONE. The word is latched on the
// start edge. LOAD takes the sign and the special cases and forms the
// magnitude. DECODE splits the magnitude into regime, exponent and fraction.
// DONE presents the result until the consumer acknowledges it.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   posit_num in   [31:0] posit word, sampled on the start edge in IDLE
//   start     in   decode request, honoured only in IDLE
//   received  in   consumer acknowledge, releases DONE
//   sign      out  posit sign bit
//   done      out  result valid, held until acknowledged
//   ZERO      out  input was 0x00000000
//   NAR       out  input was 0x80000000
//   k         out  [5:0] regime value, two's complement
//   exp_value out  [2:0] exponent field
//   mantissa  out  [31:0] hidden 1 at bit 31, fraction left-aligned below it
module posit_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] posit_num,
  input  logic        start,
  input  logic        received,
  output logic        sign,
  output logic        done,
  output logic        ZERO,
  output logic        NAR,
  output logic [5:0]  k,
  output logic [2:0]  exp_value,
  output logic [31:0] mantissa
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DECODE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [30:0] work_q, work_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic        nar_q, nar_d;
  logic [5:0]  k_q, k_d;
  logic [2:0]  exp_q, exp_d;
  logic [31:0] mant_q, mant_d;
  logic        done_q, done_d;

  // Length of the run of bits equal to bit 30, scanning downward. Stops at
  // the first opposite bit; an unbroken run covers all 31 bits.
  function automatic logic [5:0] run_len(input logic [30:0] w);
    logic [5:0] m;
    logic       stop;
    m    = 6'd0;
    stop = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (!stop && (w[i] == w[30])) begin
        m = m + 6'd1;
      end else begin
        stop = 1'b1;
      end
    end
    return m;
  endfunction

  logic [5:0]  run_m;
  logic [33:0] tail;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    work_d  = work_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    nar_d   = nar_q;
    k_d     = k_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    run_m   = 6'd0;
    tail    = 34'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = posit_num;
          state_d = LOAD;
        end
      end

      LOAD: begin
        sign_d  = word_q[31];
        zero_d  = (word_q == 32'h0000_0000);
        nar_d   = (word_q == 32'h8000_0000);
        // Only bits 30:0 of the magnitude matter; the low 31 bits of a
        // two's complement negation equal the negation of the low 31 bits.
        work_d  = word_q[31] ? (~word_q[30:0] + 31'd1) : word_q[30:0];
        state_d = DECODE;
      end

      DECODE: begin
        run_m = run_len(work_q);
        // Shift the run and its terminator out of the top; the three zero
        // pad bits make exhausted exponent positions read as 0.
        tail  = {work_q, 3'b000} << (run_m + 6'd1);
        if (zero_q || nar_q) begin
          k_d    = 6'd0;
          exp_d  = 3'd0;
          mant_d = 32'd0;
        end else begin
          k_d    = work_q[30] ? (run_m - 6'd1) : (6'd0 - run_m);
          exp_d  = tail[33:31];
          mant_d = {1'b1, tail[30:0]};
        end
        state_d = DONE;
      end

      DONE: begin
        if (received) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // done rises on the first edge spent in DONE and drops on the edge that
    // sees an acknowledge while it is already showing.
    done_d = (state_q == DONE) && !(done_q && received);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= 32'd0;
      work_q  <= 31'd0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
      k_q     <= 6'd0;
      exp_q   <= 3'd0;
      mant_q  <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      work_q  <= work_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      nar_q   <= nar_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      done_q  <= done_d;
    end
  end

  assign sign      = sign_q;
  assign done      = done_q;
  assign ZERO      = zero_q;
  assign NAR       = nar_q;
  assign k         = k_q;
  assign exp_value = exp_q;
  assign mantissa  = mant_q;

endmodule

// File: tb/tb_posit_decoder.sv
module tb_posit_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] posit_num;
  logic        start;
  logic        received;
  logic        sign;
  logic        done;
  logic        ZERO;
  logic        NAR;
  logic [5:0]  k;
  logic [2:0]  exp_value;
  logic [31:0] mantissa;

  int n_checks;
  int n_errors;

  posit_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .posit_num (posit_num),
    .start     (start),
    .received  (received),
    .sign      (sign),
    .done      (done),
    .ZERO      (ZERO),
    .NAR       (NAR),
    .k         (k),
    .exp_value (exp_value),
    .mantissa  (mantissa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: negate to magnitude, then consume bits 30..0 as a stream:
  // regime run, terminator, three exponent bits, then fraction.
  task automatic ref_decode(input logic [31:0] w,
                            output logic e_sign, output logic e_zero, output logic e_nar,
                            output logic [5:0] e_k, output logic [2:0] e_exp,
                            output logic [31:0] e_mant);
    bit          q[$];
    bit          r;
    int          m;
    int          kk;
    int          e;
    int          pos;
    logic [31:0] v;
    e_zero = (w == 32'h0);
    e_nar  = (w == 32'h8000_0000);
    e_sign = w[31];
    e_k    = 6'd0;
    e_exp  = 3'd0;
    e_mant = 32'd0;
    if (!e_zero && !e_nar) begin
      v = w[31] ? (32'd0 - w) : w;
      for (int i = 30; i >= 0; i--) q.push_back(v[i]);
      r = q[0];
      m = 0;
      while (q.size() > 0 && q[0] == r) begin
        m++;
        void'(q.pop_front());
      end
      if (q.size() > 0) void'(q.pop_front());
      kk  = r ? (m - 1) : -m;
      e_k = kk[5:0];
      e   = 0;
      for (int i = 0; i < 3; i++) begin
        e = e * 2;
        if (q.size() > 0) e = e + int'(q.pop_front());
      end
      e_exp  = e[2:0];
      e_mant = 32'h8000_0000;
      pos    = 30;
      while (q.size() > 0) begin
        if (q.pop_front()) e_mant[pos] = 1'b1;
        pos--;
      end
    end
  endtask

  // One full decode; hold > 0 keeps received low for that many cycles.
  task automatic run_decode(input logic [31:0] w, input int hold);
    logic        es, ez, en;
    logic [5:0]  ek;
    logic [2:0]  ee;
    logic [31:0] em;
    int          cyc;
    ref_decode(w, es, ez, en, ek, ee, em);
    @(negedge clk);
    posit_num = w;
    start     = 1'b1;
    received  = (hold == 0);
    @(posedge clk);
    #1;
    start     = 1'b0;
    posit_num = $urandom;
    cyc = 0;
    while (cyc < 9) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    check_eq("latency", cyc, 3);
    check_eq("sign", sign, es);
    check_eq("zero", ZERO, ez);
    check_eq("nar", NAR, en);
    check_eq("k", k, ek);
    check_eq("exp", exp_value, ee);
    check_eq("mant", mantissa, em);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check_eq("hold_done", done, 1'b1);
        check_eq("hold_mant", mantissa, em);
      end
      @(negedge clk);
      received = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("done_fall", done, 1'b0);
    check_eq("retain_k", k, ek);
  endtask

  logic [31:0] dir_words[8] = '{32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 32'h4800_0000,
                               32'hC000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0001};

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    received  = 1'b1;
    posit_num = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_sign", sign, 1'b0);
    check_eq("rst_flags", {30'd0, ZERO, NAR}, 32'd0);
    check_eq("rst_k", k, 6'd0);
    check_eq("rst_exp", exp_value, 3'd0);
    check_eq("rst_mant", mantissa, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner words, then absolute expectations for the extremes.
    foreach (dir_words[i]) run_decode(dir_words[i], 0);
    run_decode(32'h7FFF_FFFF, 0);
    check_eq("kmax_abs", k, 6'h1E);
    run_decode(32'h0000_0001, 0);
    check_eq("kmin_abs", k, 6'h22);
    run_decode(32'h4800_0000, 0);
    check_eq("exp2_abs", exp_value, 3'd2);

    // Acknowledge withheld for a dozen cycles.
    run_decode(32'h5A5A_1234, 12);

    // Random words.
    for (int i = 0; i < 40; i++) run_decode($urandom, 0);

    // Reset while in DECODE: outputs clear at once and no done follows.
    @(negedge clk);
    posit_num = 32'hC800_0000;
    start     = 1'b1;
    received  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("pre_rst_sign", sign, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_sign", sign, 1'b0);
    check_eq("arst_mant", mantissa, 32'd0);
    check_eq("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("post_rst_done", done, 1'b0);
    end

    // Decoder still works after the abort.
    run_decode(32'hC000_0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
